// File: rtl/demuxcond.sv
// Registered 1:4 valid/ready stream demultiplexer with single-entry output slots.
// Return path for the 4:1 muxcond data select; per-channel accept counters for debug.
//
// Per-slot state (one instance per channel):
//   state | meaning
//   EMPTY | slot holds no word, o_valid[n]=0
//   FULL  | slot holds a word, o_valid[n]=1
module demuxcond #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic [1:0]    i_sel,
  output logic          o_ready,
  output logic [DW-1:0] o_data0,
  output logic [DW-1:0] o_data1,
  output logic [DW-1:0] o_data2,
  output logic [DW-1:0] o_data3,
  output logic [3:0]    o_valid,
  input  logic [3:0]    i_ready,
  output logic [4*CW-1:0] o_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  logic                accept;
  logic [3:0]          load;
  logic [3:0]          valid;
  logic [3:0][DW-1:0]  data_all;

  // A full slot can still take a word when its consumer drains on the same edge.
  assign o_ready = ~valid[i_sel] | i_ready[i_sel];
  assign accept  = i_valid & o_ready;

  always_comb begin
    load = '0;
    if (accept) load[i_sel] = 1'b1;
  end

  for (genvar n = 0; n < 4; n++) begin : g_slot
    slot_state_t   state_q;
    slot_state_t   state_d;
    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= EMPTY;
      else          state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        EMPTY: if (load[n]) state_d = FULL;
        FULL:  if (i_ready[n] && !load[n]) state_d = EMPTY;
      endcase
    end

    // Data is retained after drain; only a load overwrites it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q <= '0;
        cnt_q  <= '0;
      end else if (load[n]) begin
        data_q <= i_data;
        cnt_q  <= cnt_q + CW'(1);
      end
    end

    assign valid[n]              = (state_q == FULL);
    assign data_all[n]           = data_q;
    assign o_cnt[n*CW +: CW]     = cnt_q;
  end

  assign o_valid = valid;
  assign o_data0 = data_all[0];
  assign o_data1 = data_all[1];
  assign o_data2 = data_all[2];
  assign o_data3 = data_all[3];

endmodule

// File: tb/tb_demuxcond.sv
// Self-checking bench for demuxcond: a slot model plus per-channel queues
// of expected words, popped and compared whenever a slot drains.
module tb_demuxcond;
  localparam int DW = 4;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic [1:0]    i_sel;
  logic          o_ready;
  logic [DW-1:0] o_data0, o_data1, o_data2, o_data3;
  logic [3:0]    o_valid;
  logic [3:0]    i_ready;
  logic [4*CW-1:0] o_cnt;

  demuxcond #(.DW(DW), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_sel(i_sel), .o_ready(o_ready), .o_data0(o_data0), .o_data1(o_data1),
    .o_data2(o_data2), .o_data3(o_data3), .o_valid(o_valid),
    .i_ready(i_ready), .o_cnt(o_cnt)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [4][$];
  logic [3:0]    m_valid;
  logic [DW-1:0] m_data [4];
  logic [CW-1:0] m_cnt  [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dout(input int n);
    case (n)
      0: return o_data0;
      1: return o_data1;
      2: return o_data2;
      default: return o_data3;
    endcase
  endfunction

  function automatic logic [CW-1:0] dcnt(input int n);
    return o_cnt[n*CW +: CW];
  endfunction

  task automatic model_reset();
    m_valid = '0;
    for (int n = 0; n < 4; n++) begin
      m_data[n] = '0;
      m_cnt[n]  = '0;
      exp_q[n].delete();
    end
  endtask

  // One clock cycle: drive at negedge, check comb ready, advance, check state.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [1:0] s,
                     input logic [3:0] r);
    logic exp_rdy, acc;
    logic [3:0] drn;
    i_valid = v; i_data = d; i_sel = s; i_ready = r;
    #1;
    exp_rdy = ~m_valid[s] | r[s];
    check("ready", {31'b0, o_ready}, {31'b0, exp_rdy});
    acc = v & exp_rdy;
    drn = m_valid & r;
    for (int n = 0; n < 4; n++) begin
      if (drn[n]) begin
        if (exp_q[n].size() == 0) check("underflow", 32'd1, 32'd0);
        else check($sformatf("order%0d", n), {28'b0, dout(n)}, {28'b0, exp_q[n].pop_front()});
      end
    end
    if (acc) begin
      exp_q[s].push_back(d);
      m_data[s] = d;
      m_cnt[s]  = m_cnt[s] + 1'b1;
    end
    m_valid = (m_valid & ~drn) | (acc ? (4'b0001 << s) : 4'b0000);
    @(posedge i_clk);
    @(negedge i_clk);
    check("valid", {28'b0, o_valid}, {28'b0, m_valid});
    for (int n = 0; n < 4; n++) begin
      check($sformatf("data%0d", n), {28'b0, dout(n)}, {28'b0, m_data[n]});
      check($sformatf("cnt%0d", n), {24'b0, dcnt(n)}, {24'b0, m_cnt[n]});
    end
  endtask

  logic [CW-1:0] snap [4];
  logic [DW-1:0] pat;

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_sel = '0; i_ready = '0;
    model_reset();
    #3;
    check("rst_valid", {28'b0, o_valid}, 32'd0);
    check("rst_cnt", o_cnt, 32'd0);
    check("rst_data0", {28'b0, o_data0}, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic route
    pat = 4'hA; cyc(1'b1, pat, 2'd0, 4'b1111);
    pat = 4'h5; cyc(1'b1, pat, 2'd1, 4'b1111);
    pat = 4'hC; cyc(1'b1, pat, 2'd2, 4'b1111);
    pat = 4'h3; cyc(1'b1, pat, 2'd3, 4'b1111);
    cyc(1'b0, 4'h0, 2'd0, 4'b1111);
    check("basic_cnt", o_cnt, 32'h01010101);

    // Stall on channel 2, then drain+reload on one edge
    cyc(1'b1, 4'h7, 2'd2, 4'b1011);
    cyc(1'b1, 4'h9, 2'd2, 4'b1011);
    check("stall_data2", {28'b0, o_data2}, 32'h7);
    cyc(1'b1, 4'h9, 2'd2, 4'b1011);
    cyc(1'b1, 4'h9, 2'd2, 4'b1111);
    check("reload_data2", {28'b0, o_data2}, 32'h9);
    check("reload_valid2", {31'b0, o_valid[2]}, 32'd1);
    cyc(1'b0, 4'h0, 2'd0, 4'b1111);

    // Isolation: slot 1 stalled full, slot 3 still flows
    cyc(1'b1, 4'h6, 2'd1, 4'b1101);
    cyc(1'b1, 4'hE, 2'd3, 4'b1101);
    check("iso_data3", {28'b0, o_data3}, 32'hE);
    check("iso_data1", {28'b0, o_data1}, 32'h6);
    check("iso_valid1", {31'b0, o_valid[1]}, 32'd1);
    cyc(1'b0, 4'h0, 2'd0, 4'b1111);

    // Throughput: 16 back-to-back words into channel 0
    for (int n = 0; n < 4; n++) snap[n] = dcnt(n);
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i), 2'd0, 4'b1111);
    check("thru_cnt0", {24'b0, dcnt(0) - snap[0]}, 32'd16);
    cyc(1'b0, 4'h0, 2'd0, 4'b1111);

    // Counter wrap on channel 1
    for (int n = 0; n < 4; n++) snap[n] = dcnt(n);
    for (int i = 0; i < 256; i++) cyc(1'b1, DW'($urandom), 2'd1, 4'b1111);
    for (int n = 0; n < 4; n++)
      check($sformatf("wrap_cnt%0d", n), {24'b0, dcnt(n)}, {24'b0, snap[n]});

    // Mid-cycle asynchronous reset with slots full
    cyc(1'b1, 4'hB, 2'd0, 4'b0000);
    cyc(1'b1, 4'hD, 2'd3, 4'b0000);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", {28'b0, o_valid}, 32'd0);
    check("arst_cnt", o_cnt, 32'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1'b0, 4'h0, 2'd0, 4'b0000);

    // Random traffic
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom), DW'($urandom), 2'($urandom), 4'($urandom));
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 2'd0, 4'b1111);
    for (int n = 0; n < 4; n++)
      check($sformatf("leftover%0d", n), exp_q[n].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
